// File: rtl/host_session_table_if.sv
// Config, lookup and result channels of the host/session table.
// Master side belongs to the FIX parser datapath; slave side is the table.
// No state; the table's FSM decides when each handshake takes effect.
interface host_session_table_if #(
  parameter int NUM_HOSTS   = 4,
  parameter int VALUE_BYTES = 10,
  parameter int SIZE_WIDTH  = 6,
  parameter int CNT_WIDTH   = 16
);
  localparam int IDX_WIDTH   = $clog2(NUM_HOSTS);
  localparam int VALUE_WIDTH = 8 * VALUE_BYTES;

  // config write channel
  logic                   cfg_we;
  logic                   cfg_ready;
  logic [IDX_WIDTH-1:0]   cfg_addr;
  logic [VALUE_WIDTH-1:0] cfg_value;
  logic [VALUE_BYTES-1:0] cfg_mask;
  logic                   cfg_role;
  logic [SIZE_WIDTH-1:0]  cfg_size;
  logic                   cfg_entry_en;

  // lookup request channel
  logic                   lk_valid;
  logic                   lk_ready;
  logic [VALUE_WIDTH-1:0] lk_value;
  logic [SIZE_WIDTH-1:0]  lk_len;

  // lookup result channel
  logic                   res_valid;
  logic                   res_ready;
  logic                   res_hit;
  logic [IDX_WIDTH-1:0]   res_index;
  logic                   res_role;
  logic [SIZE_WIDTH-1:0]  res_size;

  logic [CNT_WIDTH-1:0]   miss_count;

  modport master (
    output cfg_we, cfg_addr, cfg_value, cfg_mask, cfg_role, cfg_size, cfg_entry_en,
    output lk_valid, lk_value, lk_len, res_ready,
    input  cfg_ready, lk_ready, res_valid, res_hit, res_index, res_role, res_size,
    input  miss_count
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_value, cfg_mask, cfg_role, cfg_size, cfg_entry_en,
    input  lk_valid, lk_value, lk_len, res_ready,
    output cfg_ready, lk_ready, res_valid, res_hit, res_index, res_role, res_size,
    output miss_count
  );
endinterface

// File: rtl/host_session_table.sv
// Host/session CompID table: first-match sequential scan of NUM_HOSTS entries.
// Latency: hit at entry j -> result after 1+j edges; miss -> after NUM_HOSTS edges.
// Backpressure: one lookup in flight; cfg/lk only accepted in IDLE, result held until res_ready.
module host_session_table #(
  parameter int NUM_HOSTS   = 4,
  parameter int IDX_WIDTH   = $clog2(NUM_HOSTS),
  parameter int VALUE_BYTES = 10,
  parameter int VALUE_WIDTH = 8 * VALUE_BYTES,
  parameter int SIZE_WIDTH  = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  host_session_table_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                 state_q;

  // table storage; only the valid bits are reset
  logic [VALUE_WIDTH-1:0] val_q  [NUM_HOSTS];
  logic [VALUE_BYTES-1:0] mask_q [NUM_HOSTS];
  logic                   role_q [NUM_HOSTS];
  logic [SIZE_WIDTH-1:0]  size_q [NUM_HOSTS];
  logic [NUM_HOSTS-1:0]   en_q;

  // latched request and scan position
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [VALUE_WIDTH-1:0] lk_val_q;
  logic [SIZE_WIDTH-1:0]  lk_len_q;

  // registered result
  logic                   res_valid_q;
  logic                   res_hit_q;
  logic [IDX_WIDTH-1:0]   res_index_q;
  logic                   res_role_q;
  logic [SIZE_WIDTH-1:0]  res_size_q;
  logic [CNT_WIDTH-1:0]   miss_q;

  logic                   cfg_fire;
  logic                   bytes_ok;
  logic                   entry_match;
  logic                   last_idx;

  // writes are dropped outside IDLE, never queued
  assign cfg_fire = bus.cfg_we && (state_q == IDLE);
  assign last_idx = (idx_q == IDX_WIDTH'(NUM_HOSTS - 1));

  // entry payload: no reset needed, the valid bit gates every use
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      val_q[bus.cfg_addr]  <= bus.cfg_value;
      mask_q[bus.cfg_addr] <= bus.cfg_mask;
      role_q[bus.cfg_addr] <= bus.cfg_role;
      size_q[bus.cfg_addr] <= bus.cfg_size;
    end
  end

  // entry valid bits, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
    end else if (cfg_fire) begin
      en_q[bus.cfg_addr] <= bus.cfg_entry_en;
    end
  end

  // match test for the entry currently under the scan pointer
  always_comb begin
    bytes_ok = 1'b1;
    for (int i = 0; i < VALUE_BYTES; i++) begin
      if (mask_q[idx_q][i] && (val_q[idx_q][8*i +: 8] != lk_val_q[8*i +: 8])) begin
        bytes_ok = 1'b0;
      end
    end
    entry_match = en_q[idx_q] && (size_q[idx_q] == lk_len_q) && bytes_ok;
  end

  // lookup FSM: accept in IDLE, scan one entry per cycle, hold result in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lk_val_q    <= '0;
      lk_len_q    <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
      res_role_q  <= 1'b0;
      res_size_q  <= '0;
      miss_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.lk_valid) begin
            lk_val_q <= bus.lk_value;
            lk_len_q <= bus.lk_len;
            idx_q    <= '0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (entry_match) begin
            res_valid_q <= 1'b1;
            res_hit_q   <= 1'b1;
            res_index_q <= idx_q;
            res_role_q  <= role_q[idx_q];
            res_size_q  <= size_q[idx_q];
            state_q     <= RESP;
          end else if (last_idx) begin
            res_valid_q <= 1'b1;
            res_hit_q   <= 1'b0;
            res_index_q <= '0;
            res_role_q  <= 1'b0;
            res_size_q  <= '0;
            if (miss_q != {CNT_WIDTH{1'b1}}) begin
              miss_q <= miss_q + 1'b1;
            end
            state_q <= RESP;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready  = (state_q == IDLE);
  assign bus.lk_ready   = (state_q == IDLE);
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hit    = res_hit_q;
  assign bus.res_index  = res_index_q;
  assign bus.res_role   = res_role_q;
  assign bus.res_size   = res_size_q;
  assign bus.miss_count = miss_q;

endmodule

// File: tb/tb_host_session_table.sv
// Bench for host_session_table: transaction-level model plus directed cases.
module tb_host_session_table;

  localparam int NH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  host_session_table_if #(.NUM_HOSTS(NH), .VALUE_BYTES(10), .SIZE_WIDTH(6), .CNT_WIDTH(16)) bus ();

  host_session_table #(
    .NUM_HOSTS(NH), .VALUE_BYTES(10), .SIZE_WIDTH(6), .CNT_WIDTH(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [79:0] m_val  [NH];
  logic [9:0]  m_mask [NH];
  bit          m_role [NH];
  logic [5:0]  m_size [NH];
  bit          m_en   [NH];
  int          m_phase;     // 0 idle, 1 busy, 2 result shown
  int          m_wait;
  bit          p_hit;
  int          p_j;
  bit          m_valid, m_hit, m_rrole;
  logic [1:0]  m_idx;
  logic [5:0]  m_rsize;
  logic [15:0] m_miss;

  function automatic bit masked_eq(input logic [79:0] a, input logic [79:0] b, input logic [9:0] m);
    for (int i = 0; i < 10; i++)
      if (m[i] && a[8*i +: 8] != b[8*i +: 8]) return 1'b0;
    return 1'b1;
  endfunction

  // first (lowest index) matching entry of the model table
  task automatic find(input logic [79:0] v, input logic [5:0] len, output bit hit, output int j);
    hit = 1'b0;
    j = 0;
    for (int e = 0; e < NH; e++)
      if (!hit && m_en[e] && m_size[e] == len && masked_eq(m_val[e], v, m_mask[e])) begin
        hit = 1'b1;
        j = e;
      end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NH; e++) m_en[e] = 1'b0;
      m_phase = 0; m_valid = 0; m_hit = 0; m_idx = 0; m_rrole = 0; m_rsize = 0; m_miss = 0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.cfg_we) begin
            m_val[bus.cfg_addr]  = bus.cfg_value;
            m_mask[bus.cfg_addr] = bus.cfg_mask;
            m_role[bus.cfg_addr] = bus.cfg_role;
            m_size[bus.cfg_addr] = bus.cfg_size;
            m_en[bus.cfg_addr]   = bus.cfg_entry_en;
          end
          if (bus.lk_valid) begin
            find(bus.lk_value, bus.lk_len, p_hit, p_j);
            // a hit at entry j appears j+1 edges later, a miss NH edges later
            m_wait  = p_hit ? p_j : NH - 1;
            m_phase = 1;
          end
        end
        1: begin
          if (m_wait == 0) begin
            m_phase = 2;
            m_valid = 1;
            m_hit   = p_hit;
            m_idx   = p_hit ? 2'(p_j) : 2'd0;
            m_rrole = p_hit ? m_role[p_j] : 1'b0;
            m_rsize = p_hit ? m_size[p_j] : 6'd0;
            if (!p_hit && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
          end else begin
            m_wait--;
          end
        end
        default: begin
          if (bus.res_ready) begin
            m_phase = 0;
            m_valid = 0;
          end
        end
      endcase
    end
  end

  // every-cycle comparison against the model, just after the active edge
  always @(posedge clk) begin
    #1;
    chk("res_valid", 80'(bus.res_valid), 80'(m_valid));
    chk("lk_ready", 80'(bus.lk_ready), 80'(m_phase == 0));
    chk("cfg_ready", 80'(bus.cfg_ready), 80'(m_phase == 0));
    chk("miss_count", 80'(bus.miss_count), 80'(m_miss));
    if (m_valid) begin
      chk("res_hit", 80'(bus.res_hit), 80'(m_hit));
      chk("res_index", 80'(bus.res_index), 80'(m_idx));
      chk("res_role", 80'(bus.res_role), 80'(m_rrole));
      chk("res_size", 80'(bus.res_size), 80'(m_rsize));
    end
  end

  // ---------------- drivers ----------------
  task automatic cfg_write(input logic [1:0] a, input logic [79:0] v, input logic [9:0] m,
                           input bit r, input logic [5:0] s, input bit en);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_value = v; bus.cfg_mask = m;
    bus.cfg_role = r; bus.cfg_size = s; bus.cfg_entry_en = en;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // issue a lookup (optionally with a same-edge write already set up by caller),
  // wait for the result, hold res_ready low for 'hold' cycles, then consume it
  task automatic do_lookup(input logic [79:0] v, input logic [5:0] len, input int hold,
                           input bit poke, input bit with_cfg,
                           output bit hit, output logic [1:0] idx, output bit role,
                           output logic [5:0] size, output int lat);
    if (!with_cfg) @(negedge clk);
    bus.lk_valid = 1'b1; bus.lk_value = v; bus.lk_len = len;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    bus.cfg_we   = poke;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.res_valid) begin
      errors++;
      $display("FAIL lookup_timeout: res_valid still 0 after %0d cycles", lat);
    end
    hit = bus.res_hit; idx = bus.res_index; role = bus.res_role; size = bus.res_size;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("lk_ready_held_resp", 80'(bus.lk_ready), 80'd0);
      chk("res_index_stable", 80'(bus.res_index), 80'(idx));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.cfg_we    = 1'b0;
  endtask

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  localparam logic [79:0] V0 = 80'h686374616d726564726f;
  localparam logic [79:0] V2 = 80'h6f726465726d61746368;

  bit          hit, role;
  logic [1:0]  idx;
  logic [5:0]  size;
  int          lat;
  logic [79:0] v1, base [4], lv;
  logic [5:0]  lens [4];

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_value = 0; bus.cfg_mask = 0;
    bus.cfg_role = 0; bus.cfg_size = 0; bus.cfg_entry_en = 0;
    bus.lk_valid = 0; bus.lk_value = 0; bus.lk_len = 0; bus.res_ready = 0;

    repeat (3) @(negedge clk);
    chk("reset_res_valid", 80'(bus.res_valid), 80'd0);
    chk("reset_res_hit", 80'(bus.res_hit), 80'd0);
    chk("reset_miss_count", 80'(bus.miss_count), 80'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_lk_ready", 80'(bus.lk_ready), 80'd1);
    chk("reset_cfg_ready", 80'(bus.cfg_ready), 80'd1);

    // exact-match hit at entry 0: result after 1 edge
    cfg_write(2'd0, V0, 10'h3FF, 1'b0, 6'd10, 1'b1);
    do_lookup(V0, 6'd10, 0, 0, 0, hit, idx, role, size, lat);
    chk("t1_lat", 80'(lat), 80'd1);
    chk("t1_hit", 80'(hit), 80'd1);
    chk("t1_idx", 80'(idx), 80'd0);
    chk("t1_role", 80'(role), 80'd0);
    chk("t1_size", 80'(size), 80'd10);

    // hit at entry 2 with 0,1,3 invalid: result after 3 edges
    cfg_write(2'd0, V0, 10'h3FF, 1'b0, 6'd10, 1'b0);
    cfg_write(2'd2, V2, 10'h3FF, 1'b1, 6'd10, 1'b1);
    do_lookup(V2, 6'd10, 0, 0, 0, hit, idx, role, size, lat);
    chk("t2_lat", 80'(lat), 80'd3);
    chk("t2_hit", 80'(hit), 80'd1);
    chk("t2_idx", 80'(idx), 80'd2);
    chk("t2_role", 80'(role), 80'd1);

    // partial mask: only low 5 bytes compared
    v1 = rnd80();
    v1[39:0] = 40'h484354414d;
    cfg_write(2'd1, v1, 10'h01F, 1'b0, 6'd5, 1'b1);
    lv = rnd80();
    lv[39:0] = 40'h484354414d;
    do_lookup(lv, 6'd5, 0, 0, 0, hit, idx, role, size, lat);
    chk("t3_hit", 80'(hit), 80'd1);
    chk("t3_idx", 80'(idx), 80'd1);
    chk("t3_lat", 80'(lat), 80'd2);
    do_lookup(lv, 6'd6, 0, 0, 0, hit, idx, role, size, lat);
    chk("t3_len_miss", 80'(hit), 80'd0);
    chk("t3_miss_lat", 80'(lat), 80'd4);
    chk("t3_miss_count", 80'(bus.miss_count), 80'd1);
    chk("t3_miss_size", 80'(size), 80'd0);

    // entries 1 and 3 both match: lowest wins; long hold with ignored write to entry 1
    cfg_write(2'd3, v1, 10'h01F, 1'b1, 6'd5, 1'b1);
    bus.cfg_addr = 2'd1; bus.cfg_entry_en = 1'b0; bus.cfg_value = 80'd0;
    do_lookup(lv, 6'd5, 5, 1, 0, hit, idx, role, size, lat);
    chk("t4_idx", 80'(idx), 80'd1);
    do_lookup(lv, 6'd5, 0, 0, 0, hit, idx, role, size, lat);
    chk("t4_entry_kept", 80'(idx), 80'd1);
    chk("t4_entry_kept_hit", 80'(hit), 80'd1);

    // same-edge write (entry 0 invalid) and lookup: write wins
    cfg_write(2'd0, V0, 10'h3FF, 1'b0, 6'd10, 1'b1);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_value = V0; bus.cfg_mask = 10'h3FF;
    bus.cfg_role = 1'b0; bus.cfg_size = 6'd10; bus.cfg_entry_en = 1'b0;
    do_lookup(V0, 6'd10, 0, 0, 1, hit, idx, role, size, lat);
    chk("t5_write_first_miss", 80'(hit), 80'd0);
    chk("t5_miss_count", 80'(bus.miss_count), 80'd2);

    // reset during scan: no result, counters and table cleared
    @(negedge clk);
    bus.lk_valid = 1'b1; bus.lk_value = 80'h1; bus.lk_len = 6'd33;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_res_valid", 80'(bus.res_valid), 80'd0);
    chk("t6_miss_count", 80'(bus.miss_count), 80'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_late_result", 80'(bus.res_valid), 80'd0);
    do_lookup(V2, 6'd10, 0, 0, 0, hit, idx, role, size, lat);
    chk("t6_after_reset_miss", 80'(hit), 80'd0);
    chk("t6_miss_count_1", 80'(bus.miss_count), 80'd1);

    // randomized traffic against the model
    for (int b = 0; b < 4; b++) base[b] = rnd80();
    lens[0] = 6'd5; lens[1] = 6'd10; lens[2] = 6'd63; lens[3] = 6'd0;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 99) < 45) begin
        logic [9:0] m;
        case ($urandom_range(0, 2))
          0: m = 10'h3FF;
          1: m = 10'h000;
          default: m = 10'($urandom());
        endcase
        lv = base[$urandom_range(0, 3)];
        cfg_write(2'($urandom()), lv, m, 1'($urandom()), lens[$urandom_range(0, 3)],
                  $urandom_range(0, 3) != 0);
      end else begin
        lv = base[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) lv[8*$urandom_range(0, 9) +: 8] ^= 8'h5A;
        bus.cfg_addr = 2'($urandom()); bus.cfg_value = rnd80();
        bus.cfg_entry_en = 1'($urandom()); bus.cfg_size = lens[$urandom_range(0, 3)];
        do_lookup(lv, lens[$urandom_range(0, 3)], $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, 0, hit, idx, role, size, lat);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
